// File: rtl/pkt_pkg.sv
// pkt_pkg: shared state encoding and error codes for the packet decoder
package pkt_pkg;
   typedef enum logic [2:0] {ST_PREFIX, ST_DEST, ST_LEN, ST_DATA, ST_CRC, ST_FORWARD} state_t;
   localparam state_t ST_DEFAULT = ST_PREFIX;
   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_CRC     = 3'd1;
   localparam logic [2:0] ERR_DEST    = 3'd2;
   localparam logic [2:0] ERR_LEN     = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear and fall-through read data
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             rd,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   assign empty = wp == rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign dout = mem[rp[AW-1:0]];
   always_ff @(posedge clk)
      if (wr && !full) mem[wp[AW-1:0]] <= din;
   always_ff @(posedge clk) begin
      if (!n_rst || clr) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr && !full) wp <= wp + 1'b1;
         if (rd && !empty) rp <= rp + 1'b1;
      end
   end
endmodule

// File: rtl/pkt_decoder.sv
// pkt_decoder: parses prefix/dest/len/payload/checksum frames and forwards
// the buffered payload with a one-hot destination strobe
module pkt_decoder
   import pkt_pkg::*;
#(
   parameter int         N_SRC       = 8,
   parameter int         FIFO_DEPTH  = 64,
   parameter logic [7:0] PREFIX      = 8'hAA,
   parameter bit         CHECK_CRC   = 1,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [7:0]       q,
   output logic [N_SRC-1:0] valid_bus,
   output logic             err_crc,
   output logic             err_dest,
   output logic             err_len,
   output logic             err_timeout,
   output logic             busy
);
   localparam int TW = $clog2(TIMEOUT_CYC);
   state_t state;
   logic [7:0] dest, len, cnt, sum, dout;
   logic [TW-1:0] tcnt;
   logic [2:0] err_code;
   logic bad_dest, accept, tmo, crc_ok, wr, rd, clr, empty, full;
   assign rx_ready = state != ST_FORWARD;
   assign accept = rx_valid && rx_ready;
   assign busy = state != ST_PREFIX;
   assign tmo = !accept && tcnt == TW'(TIMEOUT_CYC - 1);
   assign crc_ok = !CHECK_CRC || rx_data == sum;
   assign wr = accept && state == ST_DATA && !bad_dest;
   assign rd = state == ST_FORWARD;
   assign clr = tmo || (accept && state == ST_CRC && !(crc_ok && !bad_dest));
   assign err_crc = err_code == ERR_CRC;
   assign err_dest = err_code == ERR_DEST;
   assign err_len = err_code == ERR_LEN;
   assign err_timeout = err_code == ERR_TIMEOUT;
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .n_rst(n_rst), .clr(clr), .wr(wr), .din(rx_data),
      .rd(rd), .dout(dout), .empty(empty), .full(full)
   );
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state <= ST_DEFAULT;
         dest <= '0;
         len <= '0;
         cnt <= '0;
         sum <= '0;
         bad_dest <= 1'b0;
         tcnt <= '0;
         err_code <= ERR_NONE;
         q <= '0;
         valid_bus <= '0;
      end else begin
         err_code <= ERR_NONE;
         valid_bus <= rd ? N_SRC'(1) << dest : '0;
         if (rd) q <= dout;
         // idle-time counter only runs while a frame is being received
         tcnt <= (accept || tmo || state == ST_PREFIX || state == ST_FORWARD) ? '0 : tcnt + TW'(1);
         if (tmo) begin
            state <= ST_PREFIX;
            cnt <= '0;
            sum <= '0;
            err_code <= ERR_TIMEOUT;
         end else begin
            case (state)
               ST_PREFIX: if (accept && rx_data == PREFIX) state <= ST_DEST;
               ST_DEST: if (accept) begin
                  dest <= rx_data;
                  bad_dest <= int'(rx_data) >= N_SRC;
                  state <= ST_LEN;
               end
               ST_LEN: if (accept) begin
                  if (rx_data == 8'd0 || int'(rx_data) > FIFO_DEPTH) begin
                     err_code <= ERR_LEN;
                     state <= ST_PREFIX;
                  end else begin
                     len <= rx_data;
                     sum <= '0;
                     cnt <= '0;
                     state <= ST_DATA;
                  end
               end
               ST_DATA: if (accept) begin
                  sum <= sum + rx_data;
                  cnt <= cnt + 8'd1;
                  if (cnt == len - 8'd1) state <= ST_CRC;
               end
               ST_CRC: if (accept) begin
                  cnt <= '0;
                  if (crc_ok && !bad_dest) state <= ST_FORWARD;
                  else begin
                     err_code <= bad_dest ? ERR_DEST : ERR_CRC;
                     state <= ST_PREFIX;
                  end
               end
               ST_FORWARD: begin
                  cnt <= cnt + 8'd1;
                  if (cnt == len - 8'd1) state <= ST_PREFIX;
               end
               default: state <= ST_PREFIX;
            endcase
         end
      end
   end
   a_fwd_nonempty: assert property (@(posedge clk) disable iff (!n_rst) state == ST_FORWARD |-> !empty);
   a_no_overflow: assert property (@(posedge clk) disable iff (!n_rst) !(wr && full));
endmodule

// File: tb/tb_pkt_decoder.sv
// tb_pkt_decoder: scoreboard bench driving two decoders (checksum on / off)
module tb_pkt_decoder;
   typedef struct {int kind; int dest; int data;} ev_t;
   logic clk = 0, n_rst = 0, v = 0;
   logic [7:0] rx_data = 0;
   int tgt = 0, errors = 0, checks = 0;
   bit gaps = 0;
   ev_t q0[$], q1[$];
   logic rdy0, rdy1, ec0, ed0, el0, et0, b0, ec1, ed1, el1, et1, b1;
   logic [7:0] qo0, qo1, vb0, vb1;
   always #5 clk = ~clk;

   pkt_decoder #(.N_SRC(8), .FIFO_DEPTH(64), .PREFIX(8'hAA), .CHECK_CRC(1), .TIMEOUT_CYC(20)) u_dut (
      .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(v && tgt == 0), .rx_ready(rdy0),
      .q(qo0), .valid_bus(vb0), .err_crc(ec0), .err_dest(ed0), .err_len(el0),
      .err_timeout(et0), .busy(b0));
   pkt_decoder #(.N_SRC(8), .FIFO_DEPTH(64), .PREFIX(8'hAA), .CHECK_CRC(0), .TIMEOUT_CYC(20)) u_nc (
      .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(v && tgt == 1), .rx_ready(rdy1),
      .q(qo1), .valid_bus(vb1), .err_crc(ec1), .err_dest(ed1), .err_len(el1),
      .err_timeout(et1), .busy(b1));

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic push(input int k, input int d, input int b);
      ev_t e;
      e.kind = k;
      e.dest = d;
      e.data = b;
      if (tgt == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // kind 0 = payload byte, 1..4 = err_crc, err_dest, err_len, err_timeout
   task automatic mon(input int t, input logic [7:0] vb, input logic [7:0] qq, input logic [3:0] er);
      ev_t e;
      if (vb == 0 && er == 0) return;
      if ((t == 0 ? q0.size() : q1.size()) == 0) begin
         chk($sformatf("unexpected_out%0d vb/err", t), {vb, 4'h0, er}, 0);
         return;
      end
      if (t == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk($sformatf("err%0d", t), er, e.kind > 0 ? 4'b1 << (e.kind - 1) : 0);
      chk($sformatf("valid_bus%0d", t), vb, e.kind == 0 ? 8'b1 << e.dest : 0);
      if (e.kind == 0) chk($sformatf("q%0d", t), qq, e.data);
   endtask

   always @(negedge clk)
      if (n_rst) begin
         mon(0, vb0, qo0, {et0, el0, ed0, ec0});
         mon(1, vb1, qo1, {et1, el1, ed1, ec1});
      end

   task automatic send(input logic [7:0] b);
      int k = 0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      rx_data = b;
      v = 1;
      while (!(tgt == 1 ? rdy1 : rdy0) && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) chk("rx_ready_wait", k, 0);
      @(negedge clk);
      v = 0;
   endtask

   // expected outcome is decided from the frame's fields before any byte is sent
   task automatic frame(input int d, input int len, input bit badcrc, input bit fixed);
      logic [7:0] pl [256];
      logic [7:0] s = 0;
      for (int i = 0; i < len; i++) begin
         pl[i] = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
         s = s + pl[i];
      end
      if (len == 0 || len > 64) begin
         push(3, 0, 0);
         send(8'hAA); send(8'(d)); send(8'(len));
         return;
      end
      if (d >= 8) push(2, 0, 0);
      else if (tgt == 0 && badcrc) push(1, 0, 0);
      else for (int i = 0; i < len; i++) push(0, d, pl[i]);
      send(8'hAA); send(8'(d)); send(8'(len));
      for (int i = 0; i < len; i++) send(pl[i]);
      send(badcrc ? s + 8'd1 : s);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      logic [4:0] rv, vv;
      repeat (3) @(negedge clk);
      n_rst = 1;
      @(negedge clk);
      chk("reset_q", qo0, 0);
      chk("reset_valid_bus", vb0, 0);
      chk("reset_err", {et0, el0, ed0, ec0}, 0);
      chk("reset_busy", b0, 0);
      chk("reset_rx_ready", rdy0, 1);
      // basic frame and its latency profile
      frame(2, 3, 0, 1);
      for (int i = 0; i < 5; i++) begin
         rv[i] = rdy0;
         vv[i] = |vb0;
         @(negedge clk);
      end
      chk("rx_ready_profile", rv, 5'b11000);
      chk("valid_profile", vv, 5'b01110);
      frame(2, 3, 1, 1);
      frame(5, 2, 0, 1);
      tgt = 1;
      frame(2, 3, 1, 1);
      tgt = 0;
      frame(8, 1, 0, 1);
      frame(1, 0, 0, 1);
      frame(1, 65, 0, 1);
      frame(7, 64, 0, 1);
      // mid-frame silence aborts after the idle limit
      push(4, 0, 0);
      send(8'hAA); send(8'h01); send(8'h04); send(8'h10);
      k = 0;
      while (!et0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("timeout_cycles", k, 20);
      chk("busy_after_timeout", b0, 0);
      frame(1, 4, 0, 1);
      // a byte landing on the last idle cycle keeps the frame alive
      push(0, 1, 8'h10); push(0, 1, 8'h20); push(0, 1, 8'h30); push(0, 1, 8'h40);
      send(8'hAA); send(8'h01); send(8'h04); send(8'h10);
      repeat (19) @(negedge clk);
      send(8'h20); send(8'h30); send(8'h40); send(8'hA0);
      repeat (10) @(negedge clk);
      // prefix hunting: junk is skipped, second AA becomes dest, 00 is a bad len
      push(3, 0, 0);
      send(8'h00); send(8'hFF); send(8'hAA); send(8'hAA); send(8'h00);
      frame(3, 5, 0, 0);
      repeat (12) @(negedge clk);
      gaps = 1;
      for (int n = 0; n < 40; n++) begin
         int r, len;
         logic [7:0] g;
         tgt = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         len = r == 0 ? 0 : r == 1 ? $urandom_range(65, 255) : $urandom_range(1, 64);
         if ($urandom_range(0, 3) == 0) begin
            g = 8'($urandom);
            if (g != 8'hAA) send(g);
         end
         frame($urandom_range(0, 9), len, $urandom_range(0, 3) == 0, 0);
      end
      gaps = 0;
      k = 0;
      while ((q0.size() != 0 || q1.size() != 0) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
      // reset while payload is buffered
      tgt = 0;
      send(8'hAA); send(8'h02); send(8'h03); send(8'h11);
      n_rst = 0;
      @(negedge clk);
      chk("rst_mid_q", qo0, 0);
      chk("rst_mid_valid_bus", vb0, 0);
      chk("rst_mid_err", {et0, el0, ed0, ec0}, 0);
      chk("rst_mid_busy", b0, 0);
      chk("rst_mid_fifo_empty", u_dut.u_fifo.empty, 1);
      n_rst = 1;
      @(negedge clk);
      chk("rst_mid_rx_ready", rdy0, 1);
      frame(0, 2, 0, 0);
      repeat (10) @(negedge clk);
      chk("final_q0", q0.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
